// File: rtl/const_overlay_pipe.sv
// Registered valid/ready pass-through that forces a programmable constant field
// onto masked bit positions as each beat is captured; two-entry skid buffering.
//
// state | meaning
// ------+----------------------------------------------
// EMPTY | no beat stored; m_valid=0, s_ready=1
// ONE   | main holds a beat; m_valid=1, s_ready=1
// FULL  | main and skid hold beats; m_valid=1, s_ready=0
module const_overlay_pipe #(
  parameter int                 WIDTH     = 121,
  parameter logic [WIDTH-1:0]   MASK_INIT = '0,
  parameter logic [WIDTH-1:0]   VAL_INIT  = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic [WIDTH-1:0] cfg_val,
  output logic [CNT_W-1:0] beat_cnt,
  input  logic             cnt_clr
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] main_q, skid_q, mask_q, val_q, word;
  logic             in_fire, out_fire;
  logic             load_main, load_skid, skid_to_main;

  // Handshake flags decode only from the state register, so s_ready never sees m_ready.
  assign s_ready  = (state != FULL);
  assign m_valid  = (state != EMPTY);
  assign m_data   = main_q;
  assign in_fire  = s_valid & s_ready;
  assign out_fire = m_valid & m_ready;
  assign word     = (s_data & ~mask_q) | (val_q & mask_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          load_main = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          skid_to_main = 1'b1;
          state_nxt    = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)         main_q <= word;
      else if (skid_to_main) main_q <= skid_q;
      if (load_skid)         skid_q <= word;
    end
  end

  // The overlay in use during a capture is the one registered before that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= MASK_INIT;
      val_q  <= VAL_INIT;
    end else if (cfg_we) begin
      mask_q <= cfg_mask;
      val_q  <= cfg_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           beat_cnt <= '0;
    else if (cnt_clr)  beat_cnt <= '0;
    else if (out_fire) beat_cnt <= beat_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_const_overlay_pipe.sv
// Directed and scoreboard checks for const_overlay_pipe: reset, overlay timing,
// back-pressure ordering, random flow control, counter wrap/clear, mid-run reset.
module tb_const_overlay_pipe;

  localparam int W = 121;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready, m_valid, m_ready, cfg_we, cnt_clr;
  logic [W-1:0]  s_data, m_data, cfg_mask, cfg_val;
  logic [15:0]   beat_cnt;

  logic          s_valid4, s_ready4, m_valid4, m_ready4, cnt_clr4;
  logic [7:0]    s_data4, m_data4;
  logic [3:0]    beat_cnt4;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  const_overlay_pipe #(.WIDTH(W), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cfg_we(cfg_we), .cfg_mask(cfg_mask), .cfg_val(cfg_val),
    .beat_cnt(beat_cnt), .cnt_clr(cnt_clr)
  );

  const_overlay_pipe #(.WIDTH(8), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .s_valid(s_valid4), .s_ready(s_ready4), .s_data(s_data4),
    .m_valid(m_valid4), .m_ready(m_ready4), .m_data(m_data4),
    .cfg_we(1'b0), .cfg_mask(8'h00), .cfg_val(8'h00),
    .beat_cnt(beat_cnt4), .cnt_clr(cnt_clr4)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_valid = 0; m_ready = 0; cfg_we = 0; cnt_clr = 0;
    s_data = '0; cfg_mask = '0; cfg_val = '0;
    s_valid4 = 0; m_ready4 = 0; cnt_clr4 = 0; s_data4 = '0;
    cyc(); cyc();
    total++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready got %b want 1", s_ready); else passed++;
    total++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got %b want 0", m_valid); else passed++;
    total++; if (m_data !== '0) $display("FAIL reset_m_data got %h want 0", m_data); else passed++;
    total++; if (beat_cnt !== 16'd0) $display("FAIL reset_beat_cnt got %0d want 0", beat_cnt); else passed++;
    #2 rst = 1'b0;
    cyc();
  endtask

  task automatic test_single();
    s_valid = 1; s_data = 121'h1_2345_6789; m_ready = 1;
    cyc();
    s_valid = 0;
    total++; if (m_valid !== 1'b1) $display("FAIL single_m_valid got %b want 1", m_valid); else passed++;
    total++; if (m_data !== 121'h1_2345_6789) $display("FAIL single_m_data got %h want 123456789", m_data); else passed++;
    cyc();
    total++; if (beat_cnt !== 16'd1) $display("FAIL single_beat_cnt got %0d want 1", beat_cnt); else passed++;
    total++; if (m_valid !== 1'b0) $display("FAIL single_drain got %b want 0", m_valid); else passed++;
  endtask

  task automatic test_cfg_timing();
    logic [W-1:0] exp_b;
    exp_b = {{57{1'b1}}, 64'hFBD0_0000_FFFF_FFFF};
    s_valid = 1; s_data = '1; m_ready = 1;
    cfg_we = 1; cfg_mask = 121'h0FFF_FFFF_0000_0000; cfg_val = 121'h0BD0_0000_0000_0000;
    cyc();
    cfg_we = 0;
    total++; if (m_data !== {W{1'b1}}) $display("FAIL cfg_beat_a got %h want all-ones", m_data); else passed++;
    cyc();
    s_valid = 0;
    total++; if (m_data !== exp_b) $display("FAIL cfg_beat_b got %h want %h", m_data, exp_b); else passed++;
    cyc();
    total++; if (beat_cnt !== 16'd3) $display("FAIL cfg_beat_cnt got %0d want 3", beat_cnt); else passed++;
    cfg_we = 1; cfg_mask = '0; cfg_val = '0;
    cyc();
    cfg_we = 0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d [4];
    d[0] = 121'hD0; d[1] = 121'hD1_0000_0000_0000_0000; d[2] = 121'h1_0000_0000_0000_0000_0000_0000_00D2; d[3] = 121'hABCD_D3;
    m_ready = 0;
    s_valid = 1; s_data = d[0];
    cyc();
    total++; if (s_ready !== 1'b1) $display("FAIL bp_one_s_ready got %b want 1", s_ready); else passed++;
    s_data = d[1];
    cyc();
    total++; if (s_ready !== 1'b0) $display("FAIL bp_full_s_ready got %b want 0", s_ready); else passed++;
    s_data = d[2];
    cyc();
    total++; if (m_data !== d[0]) $display("FAIL bp_hold_d0 got %h want %h", m_data, d[0]); else passed++;
    total++; if (s_ready !== 1'b0) $display("FAIL bp_hold_s_ready got %b want 0", s_ready); else passed++;
    m_ready = 1;
    #1;
    total++; if (s_ready !== 1'b0) $display("FAIL bp_no_comb_path got %b want 0", s_ready); else passed++;
    cyc();
    total++; if (m_data !== d[1]) $display("FAIL bp_out_d1 got %h want %h", m_data, d[1]); else passed++;
    cyc();
    s_data = d[3];
    total++; if (m_data !== d[2]) $display("FAIL bp_out_d2 got %h want %h", m_data, d[2]); else passed++;
    cyc();
    s_valid = 0;
    total++; if (m_data !== d[3]) $display("FAIL bp_out_d3 got %h want %h", m_data, d[3]); else passed++;
    cyc();
    total++; if (m_valid !== 1'b0) $display("FAIL bp_drained got %b want 0", m_valid); else passed++;
  endtask

  task automatic test_random();
    logic [W-1:0] q [$];
    logic [W-1:0] mask, val, exp;
    logic [127:0] r;
    int beats = 0;
    int cycles = 0;
    int errs = 0;
    mask = {57'h0, 64'hFF00_0000_0000_F0F0};
    val  = {57'h0, 64'h5A00_0000_0000_A050};
    cfg_we = 1; cfg_mask = mask; cfg_val = val;
    cyc();
    cfg_we = 0;
    s_valid = 0;
    while (beats < 10000 && cycles < 60000) begin
      if (!s_valid) begin
        s_valid = ($urandom_range(0, 1) == 1);
        r = {$urandom, $urandom, $urandom, $urandom};
        s_data = r[W-1:0];
      end
      m_ready = ($urandom_range(0, 1) == 1);
      #1;
      if (m_valid && m_ready) begin
        total++;
        if (q.size() == 0) begin
          errs++;
          $display("FAIL rand_unexpected got %h want none", m_data);
        end else begin
          exp = q.pop_front();
          if (m_data !== exp) begin
            errs++;
            $display("FAIL rand_beat got %h want %h", m_data, exp);
          end else passed++;
        end
        beats++;
      end
      if (s_valid && s_ready) q.push_back((s_data & ~mask) | (val & mask));
      @(posedge clk);
      #1;
      if (s_valid && s_ready) s_valid = 1'b0;
      cycles++;
    end
    total++;
    if (beats < 10000) $display("FAIL rand_timeout got %0d beats want 10000", beats);
    else passed++;
    s_valid = 0; m_ready = 1;
    cyc(); cyc(); cyc();
    cfg_we = 1; cfg_mask = '0; cfg_val = '0;
    cyc();
    cfg_we = 0;
  endtask

  task automatic test_cnt_wrap();
    s_valid4 = 1; m_ready4 = 1; s_data4 = 8'h3C;
    repeat (17) cyc();
    s_valid4 = 0;
    cyc();
    total++; if (beat_cnt4 !== 4'd1) $display("FAIL cnt_wrap got %0d want 1", beat_cnt4); else passed++;
    s_valid4 = 1;
    cyc();
    s_valid4 = 0; cnt_clr4 = 1;
    cyc();
    cnt_clr4 = 0;
    total++; if (beat_cnt4 !== 4'd0) $display("FAIL cnt_clr got %0d want 0", beat_cnt4); else passed++;
    total++; if (m_valid4 !== 1'b0) $display("FAIL cnt_clr_xfer got %b want 0", m_valid4); else passed++;
  endtask

  task automatic test_reset_mid();
    cfg_we = 1; cfg_mask = '1; cfg_val = 121'h77;
    cyc();
    cfg_we = 0;
    m_ready = 0; s_valid = 1; s_data = 121'h1;
    cyc(); cyc();
    s_valid = 0;
    total++; if (s_ready !== 1'b0) $display("FAIL rmid_full got %b want 0", s_ready); else passed++;
    total++; if (m_data !== 121'h77) $display("FAIL rmid_overlay got %h want 77", m_data); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if (m_valid !== 1'b0) $display("FAIL rmid_m_valid got %b want 0", m_valid); else passed++;
    total++; if (s_ready !== 1'b1) $display("FAIL rmid_s_ready got %b want 1", s_ready); else passed++;
    total++; if (beat_cnt !== 16'd0) $display("FAIL rmid_beat_cnt got %0d want 0", beat_cnt); else passed++;
    #1 rst = 1'b0;
    cyc();
    s_valid = 1; s_data = 121'h1234_5678_9ABC; m_ready = 1;
    cyc();
    s_valid = 0;
    total++; if (m_data !== 121'h1234_5678_9ABC) $display("FAIL rmid_init_overlay got %h want 123456789abc", m_data); else passed++;
    cyc();
  endtask

  initial begin
    test_reset();
    test_single();
    test_cfg_timing();
    test_back_to_back();
    test_random();
    test_cnt_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/const_overlay_pipe.md
Name: const_overlay_pipe

Overview:
- Registered, flow-controlled pass-through of a wide data word.
- A programmable constant field is forced onto selected bit positions. All other bits pass straight from input to output.
- Generalises the fixed constant-plus-passthrough wiring used in flattened netlists: width, overlay mask and value are parameters, the overlay can be reprogrammed at run time, and a valid/ready skid stage gives full-throughput back-pressure.
- Sits between a producer and a consumer on any wide datapath that needs fixed or tie-off fields inserted.

Parameters:
WIDTH, 121, data word width in bits (>=1)
MASK_INIT, {WIDTH{1'b0}}, reset value of overlay mask; bit=1 means the output bit is forced
VAL_INIT, {WIDTH{1'b0}}, reset value of overlay value; only bits under the mask matter
CNT_W, 16, width of the accepted-beat counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
s_valid  input  1  input beat valid
s_ready  output  1  block can accept an input beat
s_data  input  WIDTH  input word
m_valid  output  1  output beat valid
m_ready  input  1  downstream accepts the output beat
m_data  output  WIDTH  overlaid output word
cfg_we  input  1  load new overlay mask and value
cfg_mask  input  WIDTH  new overlay mask
cfg_val  input  WIDTH  new overlay value
beat_cnt  output  CNT_W  number of completed output handshakes (wraps)
cnt_clr  input  1  synchronous clear of beat_cnt

Behaviour:
- One clock domain. Reset is asynchronous and active-high; all state is cleared immediately when rst rises.
- Reset values:
  - s_ready=1, m_valid=0, m_data=0, beat_cnt=0.
  - Mask register = MASK_INIT, value register = VAL_INIT.
  - Skid register empty.
- Overlay function: word = (s_data & ~mask) | (val & mask), using the mask/val registers as they are in the capture cycle.
- The overlay is applied when the beat is captured. Stored beats are never re-overlaid.
- cfg_we: mask<=cfg_mask and val<=cfg_val at the clock edge.
  - A beat accepted in the same cycle as cfg_we uses the OLD mask/val.
  - The first beat that uses the new values is the one accepted in the following cycle.
- Handshakes:
  - Input transfer when s_valid & s_ready.
  - Output transfer when m_valid & m_ready.
- Storage: one output register (main) plus one skid register, i.e. 2 entries.
- Latency: 1 cycle from input acceptance to m_valid when the block is empty.
- States by occupancy (EMPTY, ONE, FULL):
  - EMPTY: m_valid=0, s_ready=1. An input transfer moves to ONE.
  - ONE: m_valid=1, s_ready=1.
    - Input and output together: main is replaced, stay ONE.
    - Input only: beat goes to skid, move to FULL.
    - Output only: move to EMPTY.
  - FULL: m_valid=1, s_ready=0.
    - Output transfer: skid moves to main, move to ONE.
    - No input can arrive because s_ready=0.
- s_ready is a register output with no combinational path from m_ready. Full throughput of 1 beat/cycle is sustained while m_ready=1.
- m_data must hold stable while m_valid=1 and m_ready=0. Ordering is strictly FIFO.
- s_valid while s_ready=0 is ignored; the producer must hold its beat.
- beat_cnt:
  - Increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.
  - cnt_clr has priority: the next value is 0 even if a transfer happens in the same cycle.
- Reset mid-operation discards any stored beats. The first beat after reset release uses MASK_INIT/VAL_INIT.
- Mask and value are 2-state only; x/z constants are not permitted in MASK_INIT or VAL_INIT.

Test Plan:
- Reset, WIDTH=121, MASK_INIT=0, single beat s_data=121'h1_2345_6789 with m_ready=1 -> m_valid rises 1 cycle later, m_data=121'h1_2345_6789, beat_cnt=1.
- cfg_we with cfg_mask=64'h0FFF_FFFF_0000_0000 and cfg_val=64'h0BD0_0000_0000_0000 in the same cycle as beat A=all-ones, then beat B=all-ones -> A out = all-ones. B out: bits[59:32]=28'hBD0_0000, bits[63:60] and bits[31:0] and bits[120:64] = 1.
- Stream 4 beats (D0..D3), m_ready=0 from cycle 1 -> s_ready falls after 2 beats accepted, D0 held stable on m_data. Raise m_ready -> D0, D1, D2, D3 emerge in order, no loss or duplication.
- Random s_valid/m_ready at 50% each for 10k beats with a fixed overlay -> scoreboard match every beat, and s_ready never has a combinational path from m_ready (checked by assertion).
- CNT_W=4: 17 output transfers -> beat_cnt=1. Assert cnt_clr in the same cycle as a transfer -> beat_cnt=0.
- Assert rst while FULL with a reprogrammed overlay -> immediately m_valid=0, s_ready=1, beat_cnt=0, mask/val back to INIT. The next beat uses the INIT overlay.
